data_mem_ctrl: RTL

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 61 ++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: CPU read/write data memory with a one-entry write buffer and a low-priority host loader port.
module data_mem_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              rd_valid,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic              busy,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, RD_RESP, WR_COMMIT} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic pending, host_go;
  assign pending = state == WR_COMMIT;
  // host waits out any pending buffer, so a host write to the buffered address always lands last
  assign host_go = host_wr && !host_ack && !pending && !cpu_rd && !cpu_wr;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cpu_rdata <= '0;
      rd_valid  <= 1'b0;
      host_ack  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
    end else begin
      rd_valid <= 1'b0;
      host_ack <= host_go;
      busy     <= cpu_wr;
      if (pending) mem[buf_addr] <= buf_data;
      if (host_go) mem[host_addr] <= host_wdata;
      if (cpu_wr) begin
        buf_addr <= cpu_addr;
        buf_data <= cpu_wdata;
        state    <= WR_COMMIT;
        if (cpu_rd) err <= 1'b1;
      end else if (cpu_rd) begin
        cpu_rdata <= (pending && cpu_addr == buf_addr) ? buf_data : mem[cpu_addr];
        rd_valid  <= 1'b1;
        state     <= RD_RESP;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule
